// File: rtl/apb_master_req_arbiter_pkg.sv
// Shared types and defaults for the APB master request arbiter.
package apb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_STRB_W      = DEF_DATA_W / 8;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef struct packed {
    logic                  error;
    logic [DEF_DATA_W-1:0] rdata;
  } arb_rsp_t;

  // (a + b) mod n for operands already below n; avoids a divider.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/apb_master_req_arbiter_if.sv
// Command/completion bundle between the arbiter and the APB master user port.
interface apb_master_req_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int STRB_W = 4
);
  logic              transfer;
  logic              write_read;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic [STRB_W-1:0] strb_in;
  logic              transfer_done;
  logic              error;
  logic [DATA_W-1:0] rdata_out;

  modport master (
    output transfer, write_read, addr_in, wdata_in, strb_in,
    input  transfer_done, error, rdata_out
  );

  modport slave (
    input  transfer, write_read, addr_in, wdata_in, strb_in,
    output transfer_done, error, rdata_out
  );
endinterface

// File: rtl/apb_master_req_arbiter_rr_pick.sv
// Round-robin picker: rotate requests to start after last winner, take lowest, rotate back.
module apb_rr_pick
  import apb_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last,
  output logic [NUM_REQ-1:0] gnt_oh
);

  logic [IDXW-1:0]    start;
  logic [IDXW-1:0]    j;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_oh;

  always_comb begin
    start  = IDXW'(wrap_add(32'(last), 32'd1, NUM_REQ));
    j      = '0;
    rot    = '0;
    gnt_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j      = IDXW'(wrap_add(32'(start), i, NUM_REQ));
      rot[i] = req[j];
    end
    rot_oh = rot & (~rot + NUM_REQ'(1));
    for (int i = 0; i < NUM_REQ; i++) begin
      j         = IDXW'(wrap_add(32'(start), i, NUM_REQ));
      gnt_oh[j] = rot_oh[i];
    end
  end

endmodule

// File: rtl/apb_master_req_arbiter.sv
// Round-robin sharing of one APB master user port among NUM_REQ requesters.
// Optional BUSY watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STRB_W      = DEF_STRB_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0] req_strb,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_error,
  output logic                      busy,
  apb_master_req_arbiter_if.master  apb
);

  localparam int IDXW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("apb_master_req_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYC >= 1");
  end

  arb_state_e         state_q, state_d;
  logic [IDXW-1:0]    last_q, last_d, owner_q, owner_d, win_idx;
  logic [NUM_REQ-1:0] win_oh, gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d, cand_wdata;
  logic               rsp_error_q, rsp_error_d, busy_q, busy_d, xfer_q, xfer_d;
  logic               write_q, write_d, cand_write;
  logic [ADDR_W-1:0]  addr_q, addr_d, cand_addr;
  logic [STRB_W-1:0]  strb_q, strb_d, cand_strb;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
`endif

  apb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .last   (last_q),
    .gnt_oh (win_oh)
  );

  always_comb begin
    win_idx    = '0;
    cand_write = 1'b0;
    cand_addr  = '0;
    cand_wdata = '0;
    cand_strb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx    = IDXW'(i);
        cand_write = req_write[i];
        cand_addr  = req_addr[i*ADDR_W +: ADDR_W];
        cand_wdata = req_wdata[i*DATA_W +: DATA_W];
        cand_strb  = req_strb[i*STRB_W +: STRB_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;
    busy_d      = busy_q;
    xfer_d      = xfer_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + CNT_W'(1);
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          gnt_d   = win_oh;
          xfer_d  = 1'b1;
          busy_d  = 1'b1;
          owner_d = win_idx;
          write_d = cand_write;
          addr_d  = cand_addr;
          // Reads present zero data/strobes to the APB master.
          wdata_d = cand_write ? cand_wdata : '0;
          strb_d  = cand_write ? cand_strb : '0;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (apb.transfer_done) begin
          state_d     = IDLE;
          xfer_d      = 1'b0;
          busy_d      = 1'b0;
          last_d      = owner_q;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_rdata_d = write_q ? '0 : apb.rdata_out;
          rsp_error_d = apb.error;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
          state_d     = IDLE;
          xfer_d      = 1'b0;
          busy_d      = 1'b0;
          last_d      = owner_q;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      last_q      <= IDXW'(NUM_REQ - 1);
      owner_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
      xfer_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      busy_q      <= busy_d;
      xfer_q      <= xfer_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign gnt            = gnt_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;
  assign busy           = busy_q;
  assign apb.transfer   = xfer_q;
  assign apb.write_read = write_q;
  assign apb.addr_in    = addr_q;
  assign apb.wdata_in   = wdata_q;
  assign apb.strb_in    = strb_q;

endmodule
